// File: rtl/core_pkg.sv
// core_pkg: shared state encoding, PC width default and opcode constants for the core.
package core_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_e;
    localparam int PC_W_DEFAULT = 10;
    localparam logic [3:0] OP_HALT = 4'b1011;
    localparam logic [3:0] OP_LUT = 4'b1100;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: harness/decoder-facing bus of the sequencer; InstrCount exists only with PC_SEQUENCER_INSTR_COUNT_EN.
interface pc_sequencer_if import core_pkg::*; #(parameter int PC_W = PC_W_DEFAULT);
    logic Start;
    logic Halt;
    logic BranchTaken;
    logic BranchRel;
    logic [7:0] Target;
    logic Stall;
    logic [PC_W-1:0] PC;
    logic FetchValid;
    logic Ack;
`ifdef PC_SEQUENCER_INSTR_COUNT_EN
    logic [15:0] InstrCount;
    modport master(output Start, Halt, BranchTaken, BranchRel, Target, Stall, input PC, FetchValid, Ack, InstrCount);
    modport slave(input Start, Halt, BranchTaken, BranchRel, Target, Stall, output PC, FetchValid, Ack, InstrCount);
`else
    modport master(output Start, Halt, BranchTaken, BranchRel, Target, Stall, input PC, FetchValid, Ack);
    modport slave(input Start, Halt, BranchTaken, BranchRel, Target, Stall, output PC, FetchValid, Ack);
`endif
endinterface

// File: rtl/pc_sequencer_pc_next.sv
// pc_next: combinational next-PC selection (increment, absolute target, sign-extended relative offset).
module pc_next import core_pkg::*; #(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic            branch_taken_i,
    input  logic            branch_rel_i,
    input  logic [7:0]      target_i,
    output logic [PC_W-1:0] pc_o
);
    always_comb pc_o = !branch_taken_i ? pc_i + PC_W'(1)
                     : branch_rel_i    ? pc_i + PC_W'($signed(target_i))
                     :                   PC_W'(target_i);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and fetch sequencer with IDLE/RUN/DONE control and Start/Ack handshake.
// Optional instruction counter enabled by PC_SEQUENCER_INSTR_COUNT_EN.
module pc_sequencer import core_pkg::*; #(
    parameter int              PC_W       = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input logic           Clk,
    input logic           Reset,
    pc_sequencer_if.slave bus
);
    state_e          state_q;
    logic [PC_W-1:0] pc_q, pc_d;
    pc_next #(.PC_W(PC_W)) u_next (
        .pc_i(pc_q),
        .branch_taken_i(bus.BranchTaken),
        .branch_rel_i(bus.BranchRel),
        .target_i(bus.Target),
        .pc_o(pc_d)
    );
    // Stall outranks Halt and branches; Start only matters outside RUN.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
        end else if (state_q == RUN) begin
            if (!bus.Stall) begin
                if (bus.Halt) state_q <= DONE;
                else pc_q <= pc_d;
            end
        end else if (bus.Start) begin
            state_q <= RUN;
            pc_q    <= START_ADDR;
        end
    end
    assign bus.PC         = pc_q;
    assign bus.FetchValid = (state_q == RUN) && !bus.Stall;
    assign bus.Ack        = (state_q == DONE);
`ifdef PC_SEQUENCER_INSTR_COUNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge Clk) begin
        if (Reset) cnt_q <= '0;
        else if (state_q != RUN && bus.Start) cnt_q <= '0;
        else if (state_q == RUN && !bus.Stall && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign bus.InstrCount = cnt_q;
`endif
endmodule
